// File: rtl/mem_bus_arbiter.sv
// Shared 64-bit memory port arbiter between instruction fetch and load/store.
// Each access runs as one registered req/ack bus transaction. A watchdog bounds the wait.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_valid,
    output logic [63:0] if_rdata,
    output logic        if_stall_req,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic [7:0]  d_sel,
    output logic        d_valid,
    output logic [63:0] d_rdata,
    output logic        d_stall_req,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        bus_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StDWait, StIWait, StResp} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;  // 1 = data port owns the bus
    logic              kill_q, kill_d;
    logic              err_q, err_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [63:0]       mem_addr_q, mem_addr_d;
    logic [63:0]       mem_wdata_q, mem_wdata_d;
    logic [7:0]        mem_wstrb_q, mem_wstrb_d;

    // The bus is doubleword-addressed; the low address bits never leave this block.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{d_addr[2:0], if_addr[2:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            kill_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            kill_q      <= kill_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        kill_d      = kill_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        d_valid     = 1'b0;
        if_valid    = 1'b0;
        bus_err     = 1'b0;

        case (state_q)
            StIdle: begin
                // Data wins: it belongs to the older instruction in the pipe.
                if (d_req) begin
                    owner_d     = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = {d_addr[63:3], 3'b000};
                    mem_wdata_d = d_wdata;
                    mem_wstrb_d = d_we ? d_sel : 8'h00;
                    state_d     = StDWait;
                end else if (if_req) begin
                    owner_d     = 1'b0;
                    kill_d      = flush;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = {if_addr[63:3], 3'b000};
                    mem_wdata_d = '0;
                    mem_wstrb_d = 8'h00;
                    state_d     = StIWait;
                end
            end
            StDWait, StIWait: begin
                if (state_q == StIWait && flush) begin
                    kill_d = 1'b1;
                end
                // Ack takes precedence over an expiring watchdog.
                if (mem_ack) begin
                    rdata_d   = mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = StResp;
                end else if (cnt_q == CntMax) begin
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                d_valid     = owner_q;
                if_valid    = !owner_q && !kill_q && !flush;
                bus_err     = err_q && (d_valid || if_valid);
                cnt_d       = '0;
                err_d       = 1'b0;
                kill_d      = 1'b0;
                mem_we_d    = 1'b0;
                mem_wstrb_d = 8'h00;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign d_stall_req  = d_req && !(state_q == StResp && owner_q);
    assign if_stall_req = if_req && !(state_q == StResp && !owner_q);

    assign if_rdata  = rdata_q;
    assign d_rdata   = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs change 1ns after posedge, outputs sampled at negedge.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_valid;
    logic [63:0] if_rdata;
    logic        if_stall_req;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [7:0]  d_sel;
    logic        d_valid;
    logic [63:0] d_rdata;
    logic        d_stall_req;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        bus_err;

    int n_checks = 0;
    int n_errors = 0;

    mem_bus_arbiter #(.TIMEOUT(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_valid     (if_valid),
        .if_rdata     (if_rdata),
        .if_stall_req (if_stall_req),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_sel        (d_sel),
        .d_valid      (d_valid),
        .d_rdata      (d_rdata),
        .d_stall_req  (d_stall_req),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_sel = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        cyc(); cyc();
        rst_n = 1'b1;
        smp();
        check("rst mem_req", mem_req, 0);
        check("rst mem_we", mem_we, 0);
        check("rst mem_wstrb", mem_wstrb, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst d_valid", d_valid, 0);
        check("rst if_valid", if_valid, 0);
        check("rst bus_err", bus_err, 0);
        check("rst d_rdata", d_rdata, 0);

        // Load alone, ack 3 cycles after mem_req rises
        cyc(); d_req = 1; d_we = 0; d_addr = 64'h8000_1006; d_sel = 8'hFF;
        smp(); check("ld c0 stall", d_stall_req, 1); check("ld c0 mem_req", mem_req, 0);
        cyc(); smp();
        check("ld c1 mem_req", mem_req, 1);
        check("ld c1 mem_addr", mem_addr, 64'h8000_1000);
        check("ld c1 mem_wstrb", mem_wstrb, 0);
        check("ld c1 mem_we", mem_we, 0);
        cyc(); smp();
        cyc(); smp(); check("ld c3 mem_req", mem_req, 1);
        cyc(); mem_ack = 1; mem_rdata = 64'h1122334455667788;
        smp(); check("ld c4 d_valid", d_valid, 0);
        cyc(); mem_ack = 0; mem_rdata = '0;
        smp();
        check("ld c5 d_valid", d_valid, 1);
        check("ld c5 d_rdata", d_rdata, 64'h1122334455667788);
        check("ld c5 stall", d_stall_req, 0);
        check("ld c5 bus_err", bus_err, 0);
        check("ld c5 mem_req", mem_req, 0);
        cyc(); d_req = 0;
        smp(); check("ld c6 d_valid", d_valid, 0);

        // Store and fetch requested together: store first
        cyc(); d_req = 1; d_we = 1; d_addr = 64'h10; d_sel = 8'hF0;
        d_wdata = 64'hAABBCCDD_00000000; if_req = 1; if_addr = 64'h2004;
        smp(); check("st c0 if_stall", if_stall_req, 1);
        cyc(); mem_ack = 1;
        smp();
        check("st c1 mem_req", mem_req, 1);
        check("st c1 mem_we", mem_we, 1);
        check("st c1 mem_wstrb", mem_wstrb, 8'hF0);
        check("st c1 mem_addr", mem_addr, 64'h10);
        check("st c1 mem_wdata", mem_wdata, 64'hAABBCCDD_00000000);
        cyc(); mem_ack = 0;
        smp(); check("st c2 d_valid", d_valid, 1); check("st c2 if_stall", if_stall_req, 1);
        cyc(); d_req = 0; d_we = 0; d_sel = 0; d_wdata = '0;
        smp(); check("st c3 mem_req", mem_req, 0);
        cyc(); smp();
        check("st c4 fetch mem_req", mem_req, 1);
        check("st c4 fetch mem_addr", mem_addr, 64'h2000);
        check("st c4 fetch mem_we", mem_we, 0);
        check("st c4 fetch mem_wstrb", mem_wstrb, 0);
        mem_ack = 1; mem_rdata = 64'h0000_0013_0000_0093;
        cyc(); mem_ack = 0; mem_rdata = '0;
        smp();
        check("st c5 if_valid", if_valid, 1);
        check("st c5 if_rdata", if_rdata, 64'h0000_0013_0000_0093);
        check("st c5 if_stall", if_stall_req, 0);
        cyc(); if_req = 0;
        smp(); check("st c6 if_valid", if_valid, 0);

        // Fetch killed by flush one cycle after grant
        cyc(); if_req = 1; if_addr = 64'h3008;
        cyc(); flush = 1;
        smp(); check("fl c1 mem_req", mem_req, 1);
        cyc(); flush = 0;
        smp(); check("fl c2 mem_req held", mem_req, 1);
        cyc(); smp();
        cyc(); smp();
        cyc(); mem_ack = 1; mem_rdata = 64'hDEAD;
        smp(); check("fl c5 mem_req", mem_req, 1);
        cyc(); mem_ack = 0;
        smp();
        check("fl c6 if_valid", if_valid, 0);
        check("fl c6 mem_req", mem_req, 0);
        cyc(); if_addr = 64'h4000;
        smp(); check("fl c7 mem_req", mem_req, 0);
        cyc(); mem_ack = 1; mem_rdata = 64'h4444;
        smp(); check("fl c8 mem_addr", mem_addr, 64'h4000);
        cyc(); mem_ack = 0;
        smp(); check("fl c9 if_valid", if_valid, 1); check("fl c9 if_rdata", if_rdata, 64'h4444);
        cyc(); if_req = 0;

        // Watchdog with no ack
        cyc(); d_req = 1; d_addr = 64'h40; d_sel = 8'hFF; mem_rdata = 64'h5555;
        for (int i = 1; i <= 8; i++) begin
            cyc(); smp(); check($sformatf("to c%0d mem_req", i), mem_req, 1);
        end
        cyc(); smp();
        check("to c9 mem_req", mem_req, 0);
        check("to c9 d_valid", d_valid, 1);
        check("to c9 bus_err", bus_err, 1);
        check("to c9 d_rdata", d_rdata, 0);
        cyc(); d_req = 0;
        smp(); check("to c10 d_valid", d_valid, 0); check("to c10 bus_err", bus_err, 0);

        // Ack in the final watchdog cycle wins
        cyc(); d_req = 1; d_addr = 64'h48;
        for (int i = 1; i <= 7; i++) begin
            cyc();
        end
        cyc(); mem_ack = 1; mem_rdata = 64'hCAFE;
        cyc(); mem_ack = 0; mem_rdata = '0;
        smp();
        check("ta c9 d_valid", d_valid, 1);
        check("ta c9 bus_err", bus_err, 0);
        check("ta c9 d_rdata", d_rdata, 64'hCAFE);
        cyc(); d_req = 0;

        // Stray ack while idle is ignored
        cyc(); mem_ack = 1; mem_rdata = 64'h7777;
        cyc(); mem_ack = 0;
        smp(); check("stray d_valid", d_valid, 0); check("stray mem_req", mem_req, 0);
        cyc();

        // Reset during D_WAIT, then a fresh load
        cyc(); d_req = 1; d_addr = 64'h80;
        cyc(); smp(); check("rs c1 mem_req", mem_req, 1);
        cyc(); rst_n = 0;
        cyc(); rst_n = 1; d_req = 0;
        smp(); check("rs c3 mem_req", mem_req, 0); check("rs c3 d_valid", d_valid, 0);
        cyc(); smp(); check("rs c4 d_valid", d_valid, 0);
        cyc(); d_req = 1; d_addr = 64'h88;
        cyc(); smp(); check("rs fresh mem_addr", mem_addr, 64'h88);
        cyc(); mem_ack = 1; mem_rdata = 64'h8888;
        cyc(); mem_ack = 0;
        smp(); check("rs fresh d_valid", d_valid, 1); check("rs fresh d_rdata", d_rdata, 64'h8888);
        cyc(); d_req = 0;

        // Back-to-back zero-wait loads
        cyc(); d_req = 1; d_addr = 64'h100;
        cyc(); mem_ack = 1; mem_rdata = 64'h1;
        smp(); check("bb c1 mem_req", mem_req, 1);
        cyc(); mem_ack = 0;
        smp(); check("bb c2 d_valid", d_valid, 1); check("bb c2 mem_req", mem_req, 0);
        cyc(); d_addr = 64'h108;
        smp(); check("bb c3 d_valid", d_valid, 0); check("bb c3 mem_req", mem_req, 0);
        cyc(); mem_ack = 1; mem_rdata = 64'h2;
        smp(); check("bb c4 mem_req", mem_req, 1); check("bb c4 mem_addr", mem_addr, 64'h108);
        check("bb c4 d_valid", d_valid, 0);
        cyc(); mem_ack = 0;
        smp(); check("bb c5 d_valid", d_valid, 1); check("bb c5 d_rdata", d_rdata, 64'h2);
        cyc(); d_req = 0;
        smp(); check("bb c6 d_valid", d_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
